// File: rtl/booth_r16_seq_mult_if.sv
// Operand/product handshake bundle for the radix-16 Booth multiplier.
// master = operand source / product consumer, slave = multiplier.
interface booth_r16_seq_mult_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_signed, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_signed, in_x, in_y, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/booth_r16_seq_mult.sv
// Sequential radix-16 Booth multiplier: one overlapping 5-bit digit per
// cycle, NDIG compute cycles per operation, signed or unsigned per request.
module booth_r16_seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_r16_seq_mult_if.slave  bus,
    output logic                 busy
);
    localparam int unsigned EXT  = 4 * ((WIDTH + 4) / 4);
    localparam int unsigned NDIG = EXT / 4;
    localparam int unsigned XW   = WIDTH + 4;
    localparam int unsigned AW   = 2 * WIDTH + 8;
    localparam int unsigned CW   = $clog2(NDIG);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [XW-1:0] x_q;
    // {Y_ext, 1'b0} shifted right by four per digit, so the current window
    // always sits in bits [4:0] instead of being muxed out by index.
    logic [EXT:0]         y_q;
    logic [CW-1:0]        cnt_q;
    logic signed [AW-1:0] acc_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 last;
    logic [4:0]           win;
    logic [3:0]           sum4;
    logic [3:0]           mag;
    logic signed [AW-1:0] xa, x3, x5, x7, mult, pp, acc_next;
    logic                 ext_y;

    assign last  = (cnt_q == CW'(NDIG - 1));
    assign ext_y = bus.in_y[WIDTH-1] & bus.in_signed;

    // Booth digit decode and partial-product formation by shift-and-add
    always_comb begin
        win  = y_q[4:0];
        sum4 = {1'b0, win[3:1]} + {3'b000, win[0]};
        mag  = win[4] ? (4'd8 - sum4) : sum4;
        xa   = {{(AW-XW){x_q[XW-1]}}, x_q};
        x3   = (xa <<< 1) + xa;
        x5   = (xa <<< 2) + xa;
        x7   = (xa <<< 3) - xa;
        case (mag)
            4'd0:    mult = '0;
            4'd1:    mult = xa;
            4'd2:    mult = xa <<< 1;
            4'd3:    mult = x3;
            4'd4:    mult = xa <<< 2;
            4'd5:    mult = x5;
            4'd6:    mult = x3 <<< 1;
            4'd7:    mult = x7;
            default: mult = xa <<< 3;
        endcase
        pp       = win[4] ? -mult : mult;
        acc_next = acc_q + (pp << {cnt_q, 2'b00});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        bus.out_p     = p_q;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, digit iteration and product capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            p_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= {{4{bus.in_x[WIDTH-1] & bus.in_signed}}, bus.in_x};
                        y_q   <= {{(EXT-WIDTH){ext_y}}, bus.in_y, 1'b0};
                        cnt_q <= '0;
                        acc_q <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    y_q   <= y_q >> 4;
                    if (last) p_q <= acc_next[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r16_seq_mult.sv
// Self-checking bench for booth_r16_seq_mult at WIDTH=32 and WIDTH=8.
module tb_booth_r16_seq_mult;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32_n, rst8_n, busy32, busy8;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    booth_r16_seq_mult_if #(.WIDTH(32)) b32 ();
    booth_r16_seq_mult_if #(.WIDTH(8))  b8  ();

    booth_r16_seq_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .bus(b32.slave), .busy(busy32)
    );
    booth_r16_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .bus(b8.slave), .busy(busy8)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference products from plain wide arithmetic on extended operands
    function automatic logic [63:0] ref32(input bit s, input logic [31:0] x, input logic [31:0] y);
        logic signed [64:0]  a, b;
        logic signed [129:0] p;
        a = s ? {{33{x[31]}}, x} : {33'b0, x};
        b = s ? {{33{y[31]}}, y} : {33'b0, y};
        p = a * b;
        return p[63:0];
    endfunction

    function automatic logic [15:0] ref8(input bit s, input logic [7:0] x, input logic [7:0] y);
        logic signed [16:0] a, b;
        logic signed [33:0] p;
        a = s ? {{9{x[7]}}, x} : {9'b0, x};
        b = s ? {{9{y[7]}}, y} : {9'b0, y};
        p = a * b;
        return p[15:0];
    endfunction

    // Scoreboard: expected products queued at acceptance, checked on every valid cycle
    logic [63:0] q32[$];
    logic [15:0] q8[$];
    int          acc32, acc8;
    bit          pv32, pv8;

    always @(negedge clk) begin
        if (!rst32_n) begin
            q32.delete();
            pv32 = 1'b0;
        end else begin
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(ref32(b32.in_signed, b32.in_x, b32.in_y));
                acc32 = cyc + 1;
            end
            if (b32.out_valid) begin
                if (q32.size() == 0) chk("sb32_spurious_valid", 64'(b32.out_valid), 64'd0);
                else begin
                    chk("sb32_product", b32.out_p, q32[0]);
                    chk("sb32_in_ready_low", 64'(b32.in_ready), 64'd0);
                    if (!pv32) chk("sb32_latency", 64'(cyc - acc32), 64'd9);
                    if (b32.out_ready) void'(q32.pop_front());
                end
            end
            pv32 = b32.out_valid;
        end
        if (!rst8_n) begin
            q8.delete();
            pv8 = 1'b0;
        end else begin
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(ref8(b8.in_signed, b8.in_x, b8.in_y));
                acc8 = cyc + 1;
            end
            if (b8.out_valid) begin
                if (q8.size() == 0) chk("sb8_spurious_valid", 64'(b8.out_valid), 64'd0);
                else begin
                    chk("sb8_product", 64'(b8.out_p), 64'(q8[0]));
                    chk("sb8_in_ready_low", 64'(b8.in_ready), 64'd0);
                    if (!pv8) chk("sb8_latency", 64'(cyc - acc8), 64'd3);
                    if (b8.out_ready) void'(q8.pop_front());
                end
            end
            pv8 = b8.out_valid;
        end
    end

    // One 32-bit operation; exp is checked when use_exp, hold = stall cycles in DONE
    task automatic op32(input string name, input bit s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit use_exp, input int hold, input bit early);
        int n;
        b32.in_signed = s; b32.in_x = x; b32.in_y = y; b32.in_valid = 1'b1;
        b32.out_ready = early;
        n = 0;
        while (!b32.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b32.in_valid = 1'b0; b32.in_x = $urandom; b32.in_y = $urandom; b32.in_signed = ~s;
        n = 0;
        while (!b32.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (use_exp) begin
            chk({name, "_latency"}, 64'(n), 64'd9);
            chk(name, b32.out_p, exp);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 64'(b32.out_valid), 64'd1);
            chk({name, "_hold_in_ready"}, 64'(b32.in_ready), 64'd0);
            chk({name, "_hold_p"}, b32.out_p, exp);
        end
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(b32.out_valid), 64'd0);
        chk({name, "_ready_back"}, 64'(b32.in_ready), 64'd1);
    endtask

    task automatic op8(input string name, input bit s, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp, input bit use_exp, input bit early);
        int n;
        b8.in_signed = s; b8.in_x = x; b8.in_y = y; b8.in_valid = 1'b1;
        b8.out_ready = early;
        n = 0;
        while (!b8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.in_x = 8'($urandom); b8.in_y = 8'($urandom); b8.in_signed = ~s;
        n = 0;
        while (!b8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (use_exp) begin
            chk({name, "_latency"}, 64'(n), 64'd3);
            chk(name, 64'(b8.out_p), 64'(exp));
        end else begin
            chk({name, "_valid_seen"}, 64'(b8.out_valid), 64'd1);
        end
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(b8.out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst32_n = 1'b0; rst8_n = 1'b0;
        b32.in_valid = 1'b0; b32.in_signed = 1'b0; b32.in_x = '0; b32.in_y = '0; b32.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.in_signed  = 1'b0; b8.in_x  = '0; b8.in_y  = '0; b8.out_ready  = 1'b0;
        #2;
        chk("rst32_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst32_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst32_out_p", b32.out_p, 64'd0);
        chk("rst32_busy", 64'(busy32), 64'd0);
        chk("rst8_in_ready", 64'(b8.in_ready), 64'd1);
        chk("rst8_out_p", 64'(b8.out_p), 64'd0);
        @(posedge clk); #1;
        rst32_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit directed vectors
        op32("u_ffff_sq",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1, 0, 1'b0);
        op32("s_min_sq",    1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1, 0, 1'b0);
        op32("s_m1_x3",     1'b1, 32'hFFFFFFFF, 32'h00000003, 64'hFFFFFFFFFFFFFFFD, 1'b1, 0, 1'b1);
        op32("u_msb_x2",    1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b1, 0, 1'b0);
        op32("s_msb_x2",    1'b1, 32'h80000000, 32'h00000002, 64'hFFFFFFFF00000000, 1'b1, 0, 1'b0);
        op32("u_zero",      1'b0, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 1'b1, 0, 1'b0);
        op32("s_max_min",   1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, 1'b1, 0, 1'b0);
        op32("u_2p16_sq",   1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b1, 0, 1'b1);
        op32("backpress",   1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F, 1'b1, 5, 1'b0);

        // Reset during the fourth compute cycle
        b32.in_signed = 1'b0; b32.in_x = 32'h12345678; b32.in_y = 32'h9ABCDEF0; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midop_busy_before", 64'(busy32), 64'd1);
        rst32_n = 1'b0;
        #1;
        chk("midop_rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("midop_rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("midop_rst_busy", 64'(busy32), 64'd0);
        #4;
        rst32_n = 1'b1;
        @(posedge clk); #1;
        op32("after_rst_7x6", 1'b0, 32'd7, 32'd6, 64'd42, 1'b1, 0, 1'b0);

        for (int i = 0; i < 60; i++)
            op32("rnd32", 1'(i & 1), $urandom, $urandom, 64'd0, 1'b0, 0, 1'($urandom_range(0, 1)));

        // 8-bit build
        op8("u8_ff_sq",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0);
        op8("s8_80_7f",  1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1, 1'b0);
        op8("s8_80_sq",  1'b1, 8'h80, 8'h80, 16'h4000, 1'b1, 1'b1);
        op8("s8_m1_sq",  1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1, 1'b0);
        op8("u8_zero",   1'b0, 8'h00, 8'h9C, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 500; i++)
            op8("rnd8_u", 1'b0, 8'($urandom), 8'($urandom), 16'd0, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 500; i++)
            op8("rnd8_s", 1'b1, 8'($urandom), 8'($urandom), 16'd0, 1'b0, 1'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        #1;
        chk("sb32_drained", 64'(q32.size()), 64'd0);
        chk("sb8_drained", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/booth_r16_seq_mult.md
Name: booth_r16_seq_mult

Overview:
- Sequential, parametrised radix-16 Booth multiplier. Generates one overlapping 5-bit Booth digit per cycle and accumulates the resulting partial product.
- Successor to the fixed 32-bit combinational partial-product bank, which produces eight PPs at once and is unsigned-only.
- Adds a per-operation signed/unsigned mode and valid/ready handshakes on both sides.
- Sits in the floating-point datapath as the mantissa multiplier and also serves integer multiply.

Parameters:
- WIDTH, 32, operand width in bits (min 4).
- EXT, 4*ceil((WIDTH+1)/4), derived: extended multiplier width (36 for WIDTH=32).
- NDIG, EXT/4, derived: number of Booth digits, which equals the compute cycles (9 for WIDTH=32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_x  in  WIDTH  multiplicand
- in_y  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*WIDTH  product
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1, out_valid=0, out_p=0, busy=0.
  - Accumulator, digit counter and operand registers are cleared.
- State IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid&in_ready.
  - Latch X_ext = in_x extended to WIDTH+4 bits: sign-extended if in_signed, else zero-extended.
  - Latch Y_ext = in_y extended to EXT bits by the same rule; extension bit is in_y[WIDTH-1]&in_signed.
  - Latch mode; clear accumulator; digit counter i=0; go to CALC.
- State CALC:
  - in_ready=0.
  - Each cycle, form window w = {Y_ext[4i+3:4i], Y_ext[4i-1]}, with Y_ext[-1]=0.
  - Digit d = -8*w[4] + 4*w[3] + 2*w[2] + w[1] + w[0], range -8..+8.
  - acc <= acc + ((d*X_ext) << 4i), evaluated in 2*WIDTH+8-bit signed arithmetic; ±3X, ±5X, ±7X are formed by shift-and-add; negation by two's complement.
  - i increments each cycle. After digit NDIG-1, go to DONE.
- State DONE:
  - out_valid=1; out_p = acc[2*WIDTH-1:0], which is the exact product in both modes.
  - out_p is held stable while out_valid&!out_ready.
  - On the out_valid&out_ready edge, go to IDLE; out_valid drops the next cycle; out_p keeps its last value.
- Latency:
  - Acceptance edge at t0 → out_valid high after edge t0+NDIG (NDIG cycles).
  - Minimum issue interval is NDIG+2 cycles: one operation in flight, no overlap.
- Boundaries:
  - in_valid while not IDLE: ignored (in_ready=0); inputs must be held by the source per valid/ready rules.
  - Operand or mode changes after acceptance have no effect.
  - Zero operand still takes the full NDIG cycles.
  - Most-negative signed operands are exact: WIDTH+4-bit X_ext gives headroom for 8X.
  - Unsigned in_y with MSB=1 is correct because EXT > WIDTH guarantees a final positive digit.
  - rst_n low mid-CALC or mid-DONE: immediate return to IDLE, product discarded, out_valid=0 asynchronously.
  - out_ready high while not in DONE has no effect.

Test Plan:
- WIDTH=32, unsigned, X=Y=0xFFFFFFFF → out_p=0xFFFFFFFE00000001 exactly 9 cycles after acceptance.
- WIDTH=32, signed, X=Y=0x80000000 → out_p=0x4000000000000000; signed X=0xFFFFFFFF, Y=0x00000003 → out_p=0xFFFFFFFFFFFFFFFD.
- WIDTH=32, unsigned X=0x80000000, Y=0x00000002 → 0x0000000100000000; the same operands signed → 0xFFFFFFFF00000000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_p stable, in_ready=0; raise out_ready → out_valid falls next cycle, in_ready=1.
- Reset mid-operation: drop rst_n during the 4th CALC cycle → out_valid=0, in_ready=1 immediately; next op 7×6 unsigned → 42.
- WIDTH=8 build (NDIG=3): unsigned 0xFF×0xFF → 0xFE01 after 3 cycles; signed 0x80×0x7F → 0xC080; 500 random ops in each mode match a reference model.
